// File: rtl/npu_pkg.sv
// Shared NPU local-memory definitions: controller FSM states and default geometry.
package npu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_READ    = 2'd1,
        ST_WAIT_WR = 2'd2,
        ST_DONE    = 2'd3
    } lm_state_t;

    localparam int DW_DEF      = 8;
    localparam int AW_DEF      = 10;
    localparam int NUM_MEM_DEF = 4;

    // Select width; a single memory still needs a 1-bit select port.
    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lm_rd_mux.sv
// Registered per-port read-data select from the flattened memory read bus,
// carrying the read-valid one stage further alongside the data.
module lm_rd_mux #(
    parameter int DW      = 8,
    parameter int NUM_MEM = 4,
    parameter int SW      = 2
) (
    input  logic                  CLK,
    input  logic                  rst_x,
    input  logic                  clr,
    input  logic                  vld_p0,
    input  logic [SW-1:0]         sel,
    input  logic [NUM_MEM*DW-1:0] m_rdata,
    output logic                  vld_p1,
    output logic [DW-1:0]         rdata_p1
);

    logic [DW-1:0] sel_data;

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_MEM; i++) begin
            if (sel == SW'(i)) sel_data = m_rdata[i*DW +: DW];
        end
    end

    // p0 -> p1: operand register holds its value between valid beats
    always_ff @(posedge CLK or negedge rst_x) begin
        if (!rst_x) begin
            vld_p1   <= 1'b0;
            rdata_p1 <= '0;
        end else if (clr) begin
            vld_p1   <= 1'b0;
            rdata_p1 <= '0;
        end else begin
            vld_p1 <= vld_p0;
            if (vld_p0) rdata_p1 <= sel_data;
        end
    end

endmodule

// File: rtl/lmcnt_param.sv
// Parametrised local-memory controller: streams A/B operands to the NPU and writes C back.
// Optional CYCLES performance counter enabled by defining LMCNT_PARAM_CYCLE_COUNT_EN.
module lmcnt_param
    import npu_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int AW      = AW_DEF,
    parameter int NUM_MEM = NUM_MEM_DEF,
    localparam int SW     = sel_w(NUM_MEM)
) (
    input  logic                  CLK,
    input  logic                  rst_x,
    input  logic                  SOFT_RESET,
    input  logic                  START,
    input  logic [AW:0]           LEN,
    input  logic [SW-1:0]         A_SEL,
    input  logic [SW-1:0]         B_SEL,
    input  logic [SW-1:0]         C_SEL,
    input  logic [AW-1:0]         A_BASE,
    input  logic [AW-1:0]         B_BASE,
    input  logic [AW-1:0]         C_BASE,
    output logic                  BUSY,
    output logic                  FINISH,
    output logic                  OVERRUN,
    output logic [NUM_MEM*AW-1:0] M_RADR,
    input  logic [NUM_MEM*DW-1:0] M_RDATA,
    output logic [NUM_MEM-1:0]    M_WR,
    output logic [AW-1:0]         M_WADR,
    output logic [DW-1:0]         M_WDATA,
    output logic                  NPU_EN,
    output logic [DW-1:0]         A_RDATA,
    output logic [DW-1:0]         B_RDATA,
    input  logic                  LM_EN,
    input  logic [DW-1:0]         C_WDATA
`ifdef LMCNT_PARAM_CYCLE_COUNT_EN
    ,
    output logic [31:0]           CYCLES
`endif
);

    localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

    lm_state_t     state;
    logic [AW:0]   len_q, rcnt, wcnt;
    logic [SW-1:0] a_sel_q, b_sel_q, c_sel_q;
    logic [AW-1:0] a_base_q, b_base_q, c_base_q;
    logic          finish_q, overrun_q;
    logic          vld_p0, a_vld_p1, b_vld_p1;

    logic          start_ok, active, wr_hit, wr_last, overrun_set;
    logic [AW-1:0] rd_addr_a, rd_addr_b;

    assign start_ok    = START && (state == ST_IDLE || state == ST_DONE);
    assign active      = (state == ST_READ) || (state == ST_WAIT_WR);
    assign wr_hit      = LM_EN && active && (wcnt < len_q) && !SOFT_RESET;
    assign wr_last     = wr_hit && (wcnt == len_q - ONE);
    // A START in DONE takes the cycle, so a coincident LM_EN is neither written nor flagged.
    assign overrun_set = LM_EN && (state != ST_IDLE) && !start_ok && (wcnt == len_q);

    assign rd_addr_a = a_base_q + rcnt[AW-1:0];
    assign rd_addr_b = b_base_q + rcnt[AW-1:0];

    assign BUSY    = active;
    assign FINISH  = finish_q;
    assign OVERRUN = overrun_q;
    assign M_WADR  = c_base_q + wcnt[AW-1:0];
    assign M_WDATA = C_WDATA;

    // When A and B share a memory its single read port follows the A address.
    always_comb begin
        M_RADR = '0;
        if (state == ST_READ) begin
            for (int i = 0; i < NUM_MEM; i++) begin
                if (a_sel_q == SW'(i))      M_RADR[i*AW +: AW] = rd_addr_a;
                else if (b_sel_q == SW'(i)) M_RADR[i*AW +: AW] = rd_addr_b;
            end
        end
    end

    always_comb begin
        M_WR = '0;
        for (int i = 0; i < NUM_MEM; i++) begin
            M_WR[i] = wr_hit && (c_sel_q == SW'(i));
        end
    end

    always_ff @(posedge CLK or negedge rst_x) begin
        if (!rst_x) begin
            state     <= ST_IDLE;
            len_q     <= '0;
            rcnt      <= '0;
            wcnt      <= '0;
            a_sel_q   <= '0;
            b_sel_q   <= '0;
            c_sel_q   <= '0;
            a_base_q  <= '0;
            b_base_q  <= '0;
            c_base_q  <= '0;
            finish_q  <= 1'b0;
            overrun_q <= 1'b0;
            vld_p0    <= 1'b0;
        end else if (SOFT_RESET) begin
            state     <= ST_IDLE;
            len_q     <= '0;
            rcnt      <= '0;
            wcnt      <= '0;
            a_sel_q   <= '0;
            b_sel_q   <= '0;
            c_sel_q   <= '0;
            a_base_q  <= '0;
            b_base_q  <= '0;
            c_base_q  <= '0;
            finish_q  <= 1'b0;
            overrun_q <= 1'b0;
            vld_p0    <= 1'b0;
        end else begin
            // address issue -> p0: read data appears on M_RDATA next cycle
            vld_p0 <= (state == ST_READ);
            if (start_ok) begin
                len_q     <= LEN;
                a_sel_q   <= A_SEL;
                b_sel_q   <= B_SEL;
                c_sel_q   <= C_SEL;
                a_base_q  <= A_BASE;
                b_base_q  <= B_BASE;
                c_base_q  <= C_BASE;
                rcnt      <= '0;
                wcnt      <= '0;
                finish_q  <= 1'b0;
                overrun_q <= 1'b0;
                state     <= (LEN == '0) ? ST_DONE : ST_READ;
            end else begin
                if (state == ST_DONE) finish_q <= 1'b1;
                if (overrun_set) overrun_q <= 1'b1;
                if (wr_hit) wcnt <= wcnt + ONE;
                case (state)
                    ST_READ: begin
                        rcnt <= rcnt + ONE;
                        if (wr_last)                   state <= ST_DONE;
                        else if (rcnt == len_q - ONE) state <= ST_WAIT_WR;
                    end
                    ST_WAIT_WR: if (wr_last) state <= ST_DONE;
                    default: ;
                endcase
            end
        end
    end

    lm_rd_mux #(.DW(DW), .NUM_MEM(NUM_MEM), .SW(SW)) u_rd_a (
        .CLK      (CLK),
        .rst_x    (rst_x),
        .clr      (SOFT_RESET),
        .vld_p0   (vld_p0),
        .sel      (a_sel_q),
        .m_rdata  (M_RDATA),
        .vld_p1   (a_vld_p1),
        .rdata_p1 (A_RDATA)
    );

    lm_rd_mux #(.DW(DW), .NUM_MEM(NUM_MEM), .SW(SW)) u_rd_b (
        .CLK      (CLK),
        .rst_x    (rst_x),
        .clr      (SOFT_RESET),
        .vld_p0   (vld_p0),
        .sel      (b_sel_q),
        .m_rdata  (M_RDATA),
        .vld_p1   (b_vld_p1),
        .rdata_p1 (B_RDATA)
    );

    assign NPU_EN = a_vld_p1 && b_vld_p1;

`ifdef LMCNT_PARAM_CYCLE_COUNT_EN
    always_ff @(posedge CLK or negedge rst_x) begin
        if (!rst_x)                         CYCLES <= '0;
        else if (SOFT_RESET || start_ok)    CYCLES <= '0;
        else if (active && CYCLES != '1)    CYCLES <= CYCLES + 32'd1;
    end
`endif

endmodule

// File: tb/tb_lmcnt_param.sv
// Directed bench for lmcnt_param with a 4-bank memory model (1-cycle read latency).
module tb_lmcnt_param;

    logic        CLK = 1'b0;
    logic        rst_x, SOFT_RESET, START, LM_EN;
    logic [10:0] LEN;
    logic [1:0]  A_SEL, B_SEL, C_SEL;
    logic [9:0]  A_BASE, B_BASE, C_BASE;
    logic        BUSY, FINISH, OVERRUN, NPU_EN;
    logic [39:0] M_RADR;
    logic [31:0] M_RDATA;
    logic [3:0]  M_WR;
    logic [9:0]  M_WADR;
    logic [7:0]  M_WDATA, A_RDATA, B_RDATA, C_WDATA;
`ifdef LMCNT_PARAM_CYCLE_COUNT_EN
    logic [31:0] CYCLES;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] mem [4][1024];

    always #5 CLK = ~CLK;

    lmcnt_param dut (
        .CLK(CLK), .rst_x(rst_x), .SOFT_RESET(SOFT_RESET), .START(START), .LEN(LEN),
        .A_SEL(A_SEL), .B_SEL(B_SEL), .C_SEL(C_SEL),
        .A_BASE(A_BASE), .B_BASE(B_BASE), .C_BASE(C_BASE),
        .BUSY(BUSY), .FINISH(FINISH), .OVERRUN(OVERRUN),
        .M_RADR(M_RADR), .M_RDATA(M_RDATA), .M_WR(M_WR), .M_WADR(M_WADR), .M_WDATA(M_WDATA),
        .NPU_EN(NPU_EN), .A_RDATA(A_RDATA), .B_RDATA(B_RDATA),
        .LM_EN(LM_EN), .C_WDATA(C_WDATA)
`ifdef LMCNT_PARAM_CYCLE_COUNT_EN
        , .CYCLES(CYCLES)
`endif
    );

    // Memory banks: M0[i]=i^0x5A, M1[i]=i, M2[i]=0x80+i, M3 zero; loaded while rst_x is low.
    always @(posedge CLK) begin
        if (!rst_x) begin
            for (int i = 0; i < 1024; i++) begin
                mem[0][i] <= 8'(i) ^ 8'h5A;
                mem[1][i] <= 8'(i);
                mem[2][i] <= 8'h80 + 8'(i);
                mem[3][i] <= 8'h00;
            end
        end else begin
            for (int m = 0; m < 4; m++)
                if (M_WR[m]) mem[m][M_WADR] <= M_WDATA;
        end
        for (int m = 0; m < 4; m++)
            M_RDATA[m*8 +: 8] <= mem[m][M_RADR[m*10 +: 10]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] radr(input int m);
        return M_RADR[m*10 +: 10];
    endfunction

    task automatic cyc();
        @(negedge CLK);
    endtask

    task automatic start_xfer(input int len, input int asel, input int bsel, input int csel,
                              input int abase, input int bbase, input int cbase);
        LEN = 11'(len); A_SEL = 2'(asel); B_SEL = 2'(bsel); C_SEL = 2'(csel);
        A_BASE = 10'(abase); B_BASE = 10'(bbase); C_BASE = 10'(cbase);
        START = 1'b1;
        cyc();
        START = 1'b0;
    endtask

    task automatic write_burst(input int n, input int csel, input int cbase, input int dbase);
        for (int k = 0; k < n; k++) begin
            LM_EN = 1'b1;
            C_WDATA = 8'(dbase + k);
            #1;
            chk("wr_en", 32'(M_WR), 32'(1 << csel));
            chk("wr_adr", 32'(M_WADR), 32'((cbase + k) & 10'h3FF));
            cyc();
        end
        LM_EN = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_x = 1'b0; SOFT_RESET = 1'b0; START = 1'b0; LM_EN = 1'b0; C_WDATA = '0;
        LEN = '0; A_SEL = '0; B_SEL = '0; C_SEL = '0; A_BASE = '0; B_BASE = '0; C_BASE = '0;
        repeat (3) cyc();
        chk("rst_busy", 32'(BUSY), 0);
        chk("rst_finish", 32'(FINISH), 0);
        chk("rst_overrun", 32'(OVERRUN), 0);
        chk("rst_npu_en", 32'(NPU_EN), 0);
        chk("rst_a_rdata", 32'(A_RDATA), 0);
        chk("rst_m_wr", 32'(M_WR), 0);
        chk("rst_m_radr", 32'(M_RADR == '0), 1);
        rst_x = 1'b1;
        cyc();

        // 1: basic stream M1/M2 -> NPU, results into M3[0x10..]
        start_xfer(4, 1, 2, 3, 0, 0, 'h10);
        chk("t1_busy", 32'(BUSY), 1);
        chk("t1_radr_a0", 32'(radr(1)), 0);
        chk("t1_npu_n1", 32'(NPU_EN), 0);
        cyc();
        chk("t1_radr_a1", 32'(radr(1)), 1);
        chk("t1_npu_n2", 32'(NPU_EN), 0);
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("t1_npu_en", 32'(NPU_EN), 1);
            chk("t1_a_rdata", 32'(A_RDATA), 32'(k));
            chk("t1_b_rdata", 32'(B_RDATA), 32'('h80 + k));
        end
        cyc();
        chk("t1_npu_off", 32'(NPU_EN), 0);
        chk("t1_a_hold", 32'(A_RDATA), 3);
        write_burst(4, 3, 'h10, 'hC0);
        chk("t1_fin_early", 32'(FINISH), 0);
        chk("t1_busy_done", 32'(BUSY), 0);
        cyc();
        chk("t1_finish", 32'(FINISH), 1);
        for (int k = 0; k < 4; k++) chk("t1_mem3", 32'(mem[3]['h10 + k]), 32'('hC0 + k));

        // 2: read address wrap at the top of memory
        start_xfer(4, 0, 2, 3, 'h3FE, 0, 'h20);
        chk("t2_radr0", 32'(radr(0)), 'h3FE);
        chk("t2_radr_unsel", 32'(radr(1)), 0);
        cyc();
        chk("t2_radr1", 32'(radr(0)), 'h3FF);
        cyc();
        chk("t2_radr2", 32'(radr(0)), 'h000);
        chk("t2_a_first", 32'(A_RDATA), 'hA4);
        cyc();
        chk("t2_radr3", 32'(radr(0)), 'h001);
        repeat (3) cyc();
        write_burst(4, 3, 'h20, 'hD0);
        cyc();
        chk("t2_finish", 32'(FINISH), 1);

        // 3: zero-length start
        start_xfer(0, 1, 2, 3, 0, 0, 0);
        chk("t3_busy", 32'(BUSY), 0);
        chk("t3_fin_n1", 32'(FINISH), 0);
        chk("t3_npu_n1", 32'(NPU_EN), 0);
        cyc();
        chk("t3_fin_n2", 32'(FINISH), 1);
        chk("t3_busy_n2", 32'(BUSY), 0);
        chk("t3_npu_n2", 32'(NPU_EN), 0);

        // 4: write overrun, then START with coincident LM_EN in DONE
        start_xfer(2, 1, 2, 3, 0, 0, 'h30);
        chk("t4_fin_clr", 32'(FINISH), 0);
        chk("t4_busy", 32'(BUSY), 1);
        repeat (5) cyc();
        write_burst(2, 3, 'h30, 'hE0);
        LM_EN = 1'b1;
        #1;
        chk("t4_ovr_wr", 32'(M_WR), 0);
        chk("t4_ovr_pre", 32'(OVERRUN), 0);
        cyc();
        LM_EN = 1'b0;
        chk("t4_overrun", 32'(OVERRUN), 1);
        chk("t4_finish", 32'(FINISH), 1);
        chk("t4_mem_extra", 32'(mem[3]['h32]), 0);
        LEN = 11'd1; C_BASE = 10'h40; START = 1'b1; LM_EN = 1'b1;
        #1;
        chk("t4_start_wr", 32'(M_WR), 0);
        cyc();
        START = 1'b0; LM_EN = 1'b0;
        chk("t4_ovr_clr", 32'(OVERRUN), 0);
        chk("t4_fin_clr2", 32'(FINISH), 0);
        chk("t4_busy2", 32'(BUSY), 1);
        repeat (4) cyc();
        write_burst(1, 3, 'h40, 'hEE);
        cyc();
        chk("t4_finish2", 32'(FINISH), 1);
        chk("t4_ovr_none", 32'(OVERRUN), 0);

        // 5: SOFT_RESET mid-transfer, then a normal run
        start_xfer(8, 1, 2, 3, 'h40, 'h40, 'h50);
        cyc();
        cyc();
        chk("t5_npu_a0", 32'(A_RDATA), 'h40);
        cyc();
        chk("t5_npu_a1", 32'(A_RDATA), 'h41);
        chk("t5_npu_en", 32'(NPU_EN), 1);
        SOFT_RESET = 1'b1;
        cyc();
        SOFT_RESET = 1'b0;
        chk("t5_busy", 32'(BUSY), 0);
        chk("t5_npu_off", 32'(NPU_EN), 0);
        chk("t5_finish", 32'(FINISH), 0);
        LM_EN = 1'b1;
        #1;
        chk("t5_no_wr0", 32'(M_WR), 0);
        cyc();
        chk("t5_no_wr1", 32'(M_WR), 0);
        chk("t5_radr_idle", 32'(M_RADR == '0), 1);
        LM_EN = 1'b0;
        chk("t5_mem_untouched", 32'(mem[3]['h50]), 0);
        start_xfer(2, 1, 2, 0, 'h20, 'h20, 'h60);
        cyc();
        cyc();
        chk("t5_re_a0", 32'(A_RDATA), 'h20);
        chk("t5_re_b0", 32'(B_RDATA), 'hA0);
        cyc();
        chk("t5_re_a1", 32'(A_RDATA), 'h21);
        chk("t5_re_b1", 32'(B_RDATA), 'hA1);
        cyc();
        chk("t5_re_npu_off", 32'(NPU_EN), 0);
        cyc();
        write_burst(2, 0, 'h60, 'h11);
        cyc();
        chk("t5_re_finish", 32'(FINISH), 1);
        chk("t5_mem0", 32'(mem[0]['h61]), 'h12);

        // 6: A and B from the same memory; START while busy is ignored
        start_xfer(3, 1, 1, 2, 0, 5, 'h70);
        chk("t6_radr_shared", 32'(radr(1)), 0);
        chk("t6_radr_other", 32'(radr(2)), 0);
        LEN = 11'd0; A_BASE = 10'h100; START = 1'b1;
        cyc();
        START = 1'b0;
        chk("t6_radr_ign", 32'(radr(1)), 1);
        chk("t6_busy_ign", 32'(BUSY), 1);
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("t6_npu_en", 32'(NPU_EN), 1);
            chk("t6_a_rdata", 32'(A_RDATA), 32'(k));
            chk("t6_b_eq_a", 32'(B_RDATA), 32'(k));
        end
        cyc();
        chk("t6_npu_off", 32'(NPU_EN), 0);
        write_burst(3, 2, 'h70, 'h33);
`ifdef LMCNT_PARAM_CYCLE_COUNT_EN
        chk("t6_cycles", CYCLES, 8);
`endif
        cyc();
        chk("t6_finish", 32'(FINISH), 1);
`ifdef LMCNT_PARAM_CYCLE_COUNT_EN
        chk("t6_cycles_frozen", CYCLES, 8);
`endif
        chk("t6_mem2", 32'(mem[2]['h72]), 'h35);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/lmcnt_param.md
Name: lmcnt_param

Overview:
Parametrised local-memory controller for the NPU datapath, replacing the fixed 4×1024×8 controller.
- Streams two operand vectors (A, B) out of any of NUM_MEM local memories into the NPU.
- Writes the NPU result stream (C) back into a selected memory.
- Honours programmable base addresses and a programmable transfer length; handles length-0 starts and write overrun.
- Sits between the CPU register block, the local memory bank and the NPU core.

Parameters:
- DW, 8: data width of every memory and NPU port.
- AW, 10: address width, i.e. memory depth 2^AW.
- NUM_MEM, 4: number of local memories; derived localparam SW = clog2(NUM_MEM) is the select width.

Ports:
- CLK  in  1  clock
- rst_x  in  1  asynchronous active-low reset
- SOFT_RESET  in  1  synchronous clear, same values as reset
- START  in  1  one-cycle start pulse
- LEN  in  AW+1  element count; sampled at START
- A_SEL, B_SEL, C_SEL  in  SW each  memory selects; sampled at START
- A_BASE, B_BASE, C_BASE  in  AW each  start addresses; sampled at START
- BUSY  out  1  high outside IDLE/DONE
- FINISH  out  1  transfer-complete flag
- OVERRUN  out  1  sticky: LM_EN arrived after LEN writes
- M_RADR  out  NUM_MEM*AW  per-memory read address
- M_RDATA  in  NUM_MEM*DW  per-memory read data, 1-cycle RAM latency
- M_WR  out  NUM_MEM  per-memory write enable
- M_WADR  out  AW  shared write address
- M_WDATA  out  DW  shared write data (= C_WDATA)
- NPU_EN  out  1  A_RDATA/B_RDATA valid
- A_RDATA, B_RDATA  out  DW each  operands, registered
- LM_EN  in  1  C_WDATA valid
- C_WDATA  in  DW  result data

Behaviour:
- Reset/SOFT_RESET state: IDLE.
  - All outputs 0.
  - Counters rcnt and wcnt = 0.
  - Latched config = 0.
- FSM states: IDLE, READ, WAIT_WR, DONE.
- IDLE or DONE, START=1: latch LEN/SEL/BASE and clear FINISH, OVERRUN, rcnt and wcnt.
  - LEN=0: next state is DONE; FINISH=1 on the following edge.
  - Otherwise: next state is READ.
- START while in READ or WAIT_WR: ignored.
- READ: issue one read address per cycle, rcnt = 0..LEN-1.
  - Memory A_SEL gets A_BASE+rcnt; memory B_SEL gets B_BASE+rcnt.
  - If A_SEL==B_SEL, that memory gets A_BASE+rcnt and B data equals A data.
  - Non-selected memories: M_RADR holds 0.
  - Address addition is mod 2^AW (wrap, no error).
  - After the issue with rcnt==LEN-1, go to WAIT_WR.
- Read latency: address issued in cycle t → M_RDATA valid t+1 → A_RDATA/B_RDATA and NPU_EN registered at t+2.
  - NPU_EN is high exactly LEN consecutive cycles.
  - A_RDATA/B_RDATA hold their last value when NPU_EN=0.
- Writes: independent of the read side; legal in READ and WAIT_WR.
  - Each LM_EN with wcnt<LEN: M_WR[C_SEL]=1, M_WADR=C_BASE+wcnt (mod 2^AW), wcnt++.
  - M_WR is combinational from LM_EN.
- Completion: the write that makes wcnt==LEN moves the state to DONE.
  - FINISH=1 on the next edge and is held until START or SOFT_RESET.
  - LEN==2^AW writes every location exactly once.
- Overrun: LM_EN while wcnt==LEN (any state) → M_WR stays 0, OVERRUN=1, sticky until START.
- Same-cycle LM_EN and START in DONE: START wins; that LM_EN is not written and not counted.
- LM_EN in IDLE: ignored, no OVERRUN.
- rst_x low or SOFT_RESET mid-transfer: immediate abort to IDLE, FINISH=0, no further M_WR.

Optional Feature:
- Macro LMCNT_PARAM_CYCLE_COUNT_EN.
- Defined: adds output CYCLES [31:0].
  - Cleared at START, increments every cycle in READ/WAIT_WR, frozen in DONE, saturates at 2^32-1.
  - Used for performance readout.
- Undefined: port and counter absent; no other behaviour change.

Decomposition:
- Shared package npu_pkg:
  - FSM state enum lm_state_t.
  - Defaults DW_DEF=8, AW_DEF=10, NUM_MEM_DEF=4.
- One natural sub-module, lm_rd_mux: per-port registered read-data select from the flattened M_RDATA bus.
  - Instantiated twice (A and B), with NPU_EN valid pipe alignment.
- FSM, address generation and write side stay top-level.

Test Plan:
1. Defaults, memories preloaded with M1[i]=i, M2[i]=0x80+i; A_SEL=1, B_SEL=2, bases 0, LEN=4, START. Required:
   - NPU_EN high 4 cycles starting 2 cycles after the first READ cycle.
   - A_RDATA=0,1,2,3; B_RDATA=0x80..0x83.
   - NPU returns 4 LM_EN with C_SEL=3, C_BASE=0x10: M3[0x10..0x13] written; FINISH=1 one cycle after the 4th write.
2. A_BASE=0x3FE, LEN=4 → M_RADR for A = 0x3FE, 0x3FF, 0x000, 0x001.
3. LEN=0 START → BUSY never 1, FINISH=1 two edges after START, NPU_EN stays 0.
4. LEN=2, three LM_EN pulses → 2 writes, 3rd has M_WR=0, OVERRUN=1; next START clears OVERRUN and FINISH.
5. SOFT_RESET after 2 of 8 NPU_EN cycles → BUSY=0, NPU_EN=0, no M_WR afterwards, FINISH=0; new START runs normally.
6. A_SEL=B_SEL=1, A_BASE=0, B_BASE=5 → B_RDATA==A_RDATA each NPU_EN cycle; with LMCNT_PARAM_CYCLE_COUNT_EN defined, CYCLES equals cycles spent in READ/WAIT_WR.
